// File: rtl/pf_ddr3_dqs_eye_trainer.sv
// DQS eye trainer: steps each lane's IOD delay line until the early/late flags balance.
// Define DQS_TRAINER_WATCHDOG_EN to fail a lane after MAX_STEPS delay moves.
module pf_ddr3_dqs_eye_trainer #(
    parameter int NUM_LANES     = 2,
    parameter int DELAY_W       = 8,
    parameter int SETTLE_CYCLES = 8,
    parameter int STABLE_COUNT  = 4,
    parameter int MAX_STEPS     = 255
) (
    input  logic                         FAB_CLK,
    input  logic                         RX_SYNC_RST,
    input  logic                         START,
    input  logic [NUM_LANES-1:0]         EYE_MONITOR_EARLY,
    input  logic [NUM_LANES-1:0]         EYE_MONITOR_LATE,
    input  logic [NUM_LANES-1:0]         DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES-1:0]         DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]         DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]         DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]         EYE_MONITOR_CLEAR_FLAGS,
    output logic                         BUSY,
    output logic                         DONE,
    output logic [NUM_LANES-1:0]         LANE_LOCKED,
    output logic [NUM_LANES-1:0]         LANE_FAIL,
    output logic [NUM_LANES*DELAY_W-1:0] TAP_POS
);

    localparam int LW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int STW = $clog2(STABLE_COUNT + 1);
    localparam int SPW = $clog2(MAX_STEPS + 1);

    localparam logic [SCW-1:0] SETTLE_INIT = SCW'(SETTLE_CYCLES - 1);
    localparam logic [STW-1:0] STABLE_LOCK = STW'(STABLE_COUNT);
    localparam logic [SPW-1:0] STEP_MAX    = SPW'(MAX_STEPS);
    localparam logic [LW-1:0]  LAST_LANE   = LW'(NUM_LANES - 1);

    localparam logic signed [DELAY_W-1:0] TAP_MAX = {1'b0, {(DELAY_W-1){1'b1}}};
    localparam logic signed [DELAY_W-1:0] TAP_MIN = {1'b1, {(DELAY_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        SETTLE,
        SAMPLE,
        MOVE,
        NEXT,
        FIN
    } state_t;

    state_t                     state;
    logic [LW-1:0]              lane;
    logic [SCW-1:0]             settle_cnt;
    logic [STW-1:0]             stable_cnt;
    logic [STW-1:0]             stable_nxt;
    logic [SPW-1:0]             step_cnt;
    logic [NUM_LANES-1:0]       lane_sel;
    logic signed [DELAY_W-1:0]  tap_cur;
    logic                       early;
    logic                       late;
    logic                       oor;

    assign lane_sel   = NUM_LANES'(1) << lane;
    assign tap_cur    = TAP_POS[lane*DELAY_W +: DELAY_W];
    assign early      = EYE_MONITOR_EARLY[lane];
    assign late       = EYE_MONITOR_LATE[lane];
    assign oor        = DELAY_LINE_OUT_OF_RANGE[lane];
    assign stable_nxt = stable_cnt + 1'b1;

    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST) begin
            state                   <= IDLE;
            lane                    <= '0;
            settle_cnt              <= '0;
            stable_cnt              <= '0;
            step_cnt                <= '0;
            DELAY_LINE_MOVE         <= '0;
            DELAY_LINE_DIRECTION    <= '0;
            DELAY_LINE_LOAD         <= '0;
            EYE_MONITOR_CLEAR_FLAGS <= '0;
            BUSY                    <= 1'b0;
            DONE                    <= 1'b0;
            LANE_LOCKED             <= '0;
            LANE_FAIL               <= '0;
            TAP_POS                 <= '0;
        end else begin
            // control strobes are single-cycle unless re-armed below
            DELAY_LINE_MOVE         <= '0;
            DELAY_LINE_DIRECTION    <= '0;
            DELAY_LINE_LOAD         <= '0;
            EYE_MONITOR_CLEAR_FLAGS <= '0;
            DONE                    <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (START) begin
                        state           <= LOAD;
                        BUSY            <= 1'b1;
                        lane            <= '0;
                        LANE_LOCKED     <= '0;
                        LANE_FAIL       <= '0;
                        TAP_POS         <= '0;
                        DELAY_LINE_LOAD <= NUM_LANES'(1);
                    end
                end
                LOAD: begin
                    TAP_POS[lane*DELAY_W +: DELAY_W] <= '0;
                    stable_cnt              <= '0;
                    step_cnt                <= '0;
                    EYE_MONITOR_CLEAR_FLAGS <= lane_sel;
                    state                   <= CLEAR;
                end
                CLEAR: begin
                    settle_cnt <= SETTLE_INIT;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                SAMPLE: begin
                    if (oor) begin
                        LANE_FAIL[lane] <= 1'b1;
                        state           <= NEXT;
                    end else if (early == late) begin
                        stable_cnt <= stable_nxt;
                        if (stable_nxt == STABLE_LOCK) begin
                            LANE_LOCKED[lane] <= 1'b1;
                            state             <= NEXT;
                        end else begin
                            EYE_MONITOR_CLEAR_FLAGS <= lane_sel;
                            state                   <= CLEAR;
                        end
                    end else begin
                        // move strobe and tap update land together so direction is valid with MOVE
                        stable_cnt           <= '0;
                        DELAY_LINE_MOVE      <= lane_sel;
                        DELAY_LINE_DIRECTION <= early ? lane_sel : '0;
                        if (early) begin
                            if (tap_cur != TAP_MAX) begin
                                TAP_POS[lane*DELAY_W +: DELAY_W] <= tap_cur + DELAY_W'(1);
                            end
                        end else if (tap_cur != TAP_MIN) begin
                            TAP_POS[lane*DELAY_W +: DELAY_W] <= tap_cur - DELAY_W'(1);
                        end
                        state <= MOVE;
                    end
                end
                MOVE: begin
                    if (step_cnt != STEP_MAX) begin
                        step_cnt <= step_cnt + 1'b1;
                    end
`ifdef DQS_TRAINER_WATCHDOG_EN
                    if (step_cnt == STEP_MAX - 1'b1) begin
                        LANE_FAIL[lane] <= 1'b1;
                        state           <= NEXT;
                    end else begin
                        EYE_MONITOR_CLEAR_FLAGS <= lane_sel;
                        state                   <= CLEAR;
                    end
`else
                    EYE_MONITOR_CLEAR_FLAGS <= lane_sel;
                    state                   <= CLEAR;
`endif
                end
                NEXT: begin
                    if (lane == LAST_LANE) begin
                        DONE  <= 1'b1;
                        state <= FIN;
                    end else begin
                        lane            <= lane + 1'b1;
                        DELAY_LINE_LOAD <= lane_sel << 1;
                        state           <= LOAD;
                    end
                end
                FIN: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pf_ddr3_dqs_eye_trainer.sv
// Bench for pf_ddr3_dqs_eye_trainer: behavioural IOD delay line and eye model,
// closed-form expectations for lock/fail, tap, move count and DONE timing.
module tb_pf_ddr3_dqs_eye_trainer;

    localparam int NL   = 2;
    localparam int DW   = 4;
    localparam int SC   = 3;
    localparam int SK   = 4;
    localparam int MAXS = 5;
    localparam int TMAX = 2 ** (DW - 1) - 1;
    localparam int TMIN = -(2 ** (DW - 1));
`ifdef DQS_TRAINER_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    logic [NL-1:0] early, late, oor;
    logic [NL-1:0] mv, dir, ld, clr, locked, fail;
    logic busy, done;
    logic [NL*DW-1:0] tap;

    int c [NL] = '{0, 0};
    int r [NL] = '{10, 10};
    int d [NL] = '{0, 0};
    int ld_cnt [NL] = '{0, 0};
    int cl_cnt [NL] = '{0, 0};
    int mv_cnt [NL] = '{0, 0};
    int bad     = 0;
    int bad_now;
    int dn_cnt  = 0;
    int cyc     = 0;
    int ncmp    = 0;
    int nfail   = 0;

    pf_ddr3_dqs_eye_trainer #(
        .NUM_LANES    (NL),
        .DELAY_W      (DW),
        .SETTLE_CYCLES(SC),
        .STABLE_COUNT (SK),
        .MAX_STEPS    (MAXS)
    ) dut (
        .FAB_CLK                (clk),
        .RX_SYNC_RST            (rst),
        .START                  (start),
        .EYE_MONITOR_EARLY      (early),
        .EYE_MONITOR_LATE       (late),
        .DELAY_LINE_OUT_OF_RANGE(oor),
        .DELAY_LINE_MOVE        (mv),
        .DELAY_LINE_DIRECTION   (dir),
        .DELAY_LINE_LOAD        (ld),
        .EYE_MONITOR_CLEAR_FLAGS(clr),
        .BUSY                   (busy),
        .DONE                   (done),
        .LANE_LOCKED            (locked),
        .LANE_FAIL              (fail),
        .TAP_POS                (tap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // eye centre c, IOD usable range +/-r, IOD position d
    always_comb begin
        early = '0;
        late  = '0;
        oor   = '0;
        for (int i = 0; i < NL; i++) begin
            early[i] = d[i] < c[i];
            late[i]  = d[i] > c[i];
            oor[i]   = (d[i] > r[i]) || (d[i] < -r[i]);
        end
    end

    always_comb begin
        bad_now = 0;
        if ($countones(ld | mv | clr) > 1) bad_now = bad_now + 1;
        for (int i = 0; i < NL; i++) begin
            if (mv[i] && (dir[i] != early[i])) bad_now = bad_now + 1;
            if (!mv[i] && dir[i]) bad_now = bad_now + 1;
            if (locked[i] && fail[i]) bad_now = bad_now + 1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (ld[i]) begin
                d[i]      <= 0;
                ld_cnt[i] <= ld_cnt[i] + 1;
            end
            if (clr[i]) cl_cnt[i] <= cl_cnt[i] + 1;
            if (mv[i]) begin
                mv_cnt[i] <= mv_cnt[i] + 1;
                d[i]      <= dir[i] ? d[i] + 1 : d[i] - 1;
            end
        end
        if (done) dn_cnt <= dn_cnt + 1;
        bad <= bad + bad_now;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int tap_of(input int i);
        logic signed [DW-1:0] t;
        t = tap[i*DW +: DW];
        return int'(t);
    endfunction

    function automatic longint all_outs();
        return longint'({busy, done, locked, fail, tap, mv, dir, ld, clr});
    endfunction

    task automatic run_case(input string tag, input int c0, input int c1,
                            input int r0, input int r1, input bit mid);
        int xl [NL];
        int xf [NL];
        int xt [NL];
        int xm [NL];
        int xr [NL];
        int sl [NL];
        int sm [NL];
        int scl [NL];
        int n, m, v, sum, t0, b0, d0;
        bit got;
        c[0] = c0;
        c[1] = c1;
        r[0] = r0;
        r[1] = r1;
        sum  = 0;
        for (int i = 0; i < NL; i++) begin
            n = (c[i] < 0) ? -c[i] : c[i];
            if (n <= r[i] && (!WD || n < MAXS)) begin
                xl[i] = 1; xf[i] = 0; m = n; xr[i] = n + SK;
            end else if (WD && MAXS <= r[i] + 1) begin
                xl[i] = 0; xf[i] = 1; m = MAXS; xr[i] = m;
            end else begin
                xl[i] = 0; xf[i] = 1; m = r[i] + 1; xr[i] = m + 1;
            end
            v     = (c[i] < 0) ? -m : m;
            xt[i] = (v > TMAX) ? TMAX : ((v < TMIN) ? TMIN : v);
            xm[i] = m;
            sum   = sum + 2 + xr[i] * (SC + 2) + m;
            sl[i]  = ld_cnt[i];
            sm[i]  = mv_cnt[i];
            scl[i] = cl_cnt[i];
        end
        b0 = bad;
        d0 = dn_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        check({tag, "/busy_run"}, busy, 1);
        got = 1'b0;
        for (int k = 0; k < sum + 50; k++) begin
            start = mid && (k == sum / 2);
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check({tag, "/done_seen"}, got, 1);
        check({tag, "/done_time"}, cyc - t0, sum);
        @(negedge clk);
        check({tag, "/busy_after"}, busy, 0);
        check({tag, "/done_once"}, dn_cnt - d0, 1);
        check({tag, "/protocol"}, bad - b0, 0);
        for (int i = 0; i < NL; i++) begin
            check($sformatf("%s/lock%0d", tag, i), locked[i], xl[i]);
            check($sformatf("%s/fail%0d", tag, i), fail[i], xf[i]);
            check($sformatf("%s/tap%0d", tag, i), tap_of(i), xt[i]);
            check($sformatf("%s/moves%0d", tag, i), mv_cnt[i] - sm[i], xm[i]);
            check($sformatf("%s/loads%0d", tag, i), ld_cnt[i] - sl[i], 1);
            check($sformatf("%s/clears%0d", tag, i), cl_cnt[i] - scl[i], xr[i]);
        end
    endtask

    initial begin
        int nclr;
        bit got;
        int a0, a1, q0, q1;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset/outs", all_outs(), 0);
        rst = 1'b0;

        run_case("all_bal", 0, 0, 10, 10, 1'b0);
        run_case("early3", 3, 0, 10, 10, 1'b0);
        run_case("late_oor", 0, -5, 10, 1, 1'b0);
        run_case("sat", 9, -9, 10, 10, 1'b0);
        run_case("busy_start", 2, -1, 10, 10, 1'b1);

        c[0] = 3;
        c[1] = 0;
        r[0] = 10;
        r[1] = 10;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nclr = 0;
        got  = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (clr[0]) nclr++;
            if (nclr == 3) begin
                got = 1'b1;
                break;
            end
        end
        check("midrst/reach", got, 1);
        @(negedge clk);
        check("midrst/tap_before", tap_of(0), 2);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("midrst/outs", all_outs(), 0);
        @(negedge clk);
        check("midrst/start_in_rst", busy, 0);
        rst   = 1'b0;
        start = 1'b0;
        run_case("after_rst", 3, 0, 10, 10, 1'b0);

        for (int it = 0; it < 10; it++) begin
            a0 = int'($urandom_range(24)) - 12;
            a1 = int'($urandom_range(24)) - 12;
            q0 = int'($urandom_range(12));
            q1 = int'($urandom_range(12));
            run_case($sformatf("rnd%0d", it), a0, a1, q0, q1, (it % 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
